dmem_master: RTL and testbench
==============================

// Module: dmem_master
// PURPOSE
//  Requester-side controller for the single-port 256x16 data memory (registered
//  read, 1-cycle read latency, write on dwe at posedge). Sits between the MEM
//  stage / debug path and the memory port. Serialises single-word load, single-
//  word store and multi-word block copy requests into memory cycles.
//  Returns load data and completion pulses to the requester.
// PARAMETERS
//  AW  8   address width; memory depth is 2**AW words, addresses wrap mod 2**AW
//  DW  16  data width
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept; transfer on valid&&ready at posedge
//  req_op     in   2   00 load, 01 store, 10 copy, 11 reserved (no-op)
//  req_addr   in   AW  load/store address; copy source base
//  req_daddr  in   AW  copy destination base
//  req_len    in   AW  copy length in words (0 = no-op)
//  req_wdata  in   DW  store data
//  resp_valid out  1   1-cycle pulse: resp_data holds load result
//  resp_data  out  DW  last load result, held until next load completes
//  done       out  1   1-cycle pulse: store/copy/no-op complete
//  busy       out  1   high in every state except IDLE
//  mem_dwe    out  1   to memory write enable
//  mem_addr   out  AW  to memory address
//  mem_wdata  out  DW  to memory write data
//  mem_rdata  in   DW  from memory, valid the cycle after address was sampled
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, done, busy, mem_dwe = 0; resp_data,
//   mem_addr, mem_wdata, internal counters/holding reg = 0.
//  mem_dwe/mem_addr/mem_wdata decoded from state + regs; mem_dwe high ONLY in
//   ST and CP_WR. In IDLE mem_addr = 0, mem_dwe = 0.
//  req_ready = (state==IDLE); asserted even while resp_valid/done pulse is high.
//  States: IDLE, LD_ADDR, LD_DATA, ST, CP_RD, CP_CAP, CP_WR.
//  IDLE: on accept latch request fields. op00->LD_ADDR; op01->ST;
//   op10 len!=0 ->CP_RD (src/dst/cnt latched); op10 len==0 or op11 -> stay IDLE,
//   done=1 next cycle, no memory access.
//  Load: LD_ADDR drives mem_addr=addr; LD_DATA captures mem_rdata into resp_data,
//   resp_valid=1 for one cycle, ->IDLE. Accept edge E0 -> resp_valid seen after E2.
//  Store: ST drives mem_addr, mem_wdata, mem_dwe=1 for exactly one cycle; write at
//   E1; done pulse in cycle after E1; ->IDLE.
//  Copy, per word: CP_RD drives mem_addr=src; CP_CAP loads hold<=mem_rdata;
//   CP_WR drives mem_addr=dst, mem_wdata=hold, mem_dwe=1, then src+1, dst+1,
//   cnt-1 (mod 2**AW). cnt!=0 ->CP_RD else ->IDLE with done=1. 3 cycles/word;
//   done seen after edge E(3*len). Ascending order; overlap with dst>src
//   propagates copied data (defined, not an error).
//  Write and read never in the same cycle; no read-after-write hazard inside block.
//  resp_valid and done never high together.
//  rst mid-operation: immediate IDLE, mem_dwe drops combinationally, no pending
//   write committed at next edge; completed copy words remain in memory;
//   no resp_valid/done for the aborted request.
//  req_op/addr/etc ignored when not accepted; changing them while busy has no effect.
// TESTING
//  1 store op01 addr 0x10 wdata 0x1234, then load 0x10 -> mem_dwe 1 cycle;
//    resp_data=0x1234, resp_valid 2 edges after load accept.
//  2 preload [1]=000a,[2]=000b,[3]=000c; copy src 0x01 dst 0x80 len 3 -> [80..82]=
//    000a,000b,000c; done exactly 9 edges after accept; busy high throughout.
//  3 copy src 0xFE dst 0x40 len 4 -> reads FE,FF,00,01 (wrap); [40..43] match.
//  4 copy len 0 and op11 -> done pulse next cycle, mem_dwe never asserted.
//  5 copy len 4, assert rst after 2nd CP_WR -> busy/mem_dwe 0 same cycle; only
//    2 dest words written; no done.
//  6 req_valid held high during load -> req_ready 0 while busy; back-to-back
//    load accepted in the resp_valid cycle; no request lost or duplicated.

Source files
------------

// File: rtl/dmem_master.sv
// Requester-side controller for a single-port synchronous data memory.
// Serialises load, store and block-copy requests into single memory cycles.
module dmem_master #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_daddr,
    input  logic [AW-1:0] req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_data,
    output logic          done,
    output logic          busy,
    output logic          mem_dwe,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LD_ADDR, LD_DATA, ST, CP_RD, CP_CAP, CP_WR
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_r;   // load/store address, or copy source pointer
    logic [AW-1:0] dst_r;
    logic [AW-1:0] cnt_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] hold_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            done       <= 1'b0;
            resp_data  <= '0;
            addr_r     <= '0;
            dst_r      <= '0;
            cnt_r      <= '0;
            wdata_r    <= '0;
            hold_r     <= '0;
        end else begin
            resp_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_r  <= req_addr;
                        dst_r   <= req_daddr;
                        cnt_r   <= req_len;
                        wdata_r <= req_wdata;
                        case (req_op)
                            2'b00: state <= LD_ADDR;
                            2'b01: state <= ST;
                            2'b10: begin
                                if (req_len != '0) state <= CP_RD;
                                else               done  <= 1'b1;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                LD_ADDR: state <= LD_DATA;
                LD_DATA: begin
                    resp_data  <= mem_rdata;
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                ST: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                CP_RD: state <= CP_CAP;
                CP_CAP: begin
                    hold_r <= mem_rdata;
                    state  <= CP_WR;
                end
                CP_WR: begin
                    addr_r <= addr_r + AW'(1);
                    dst_r  <= dst_r + AW'(1);
                    cnt_r  <= cnt_r - AW'(1);
                    if (cnt_r == AW'(1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= CP_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory port is a pure decode of state so reset removes a pending write at once.
    always_comb begin
        mem_dwe   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            LD_ADDR, LD_DATA, CP_RD, CP_CAP: mem_addr = addr_r;
            ST: begin
                mem_dwe   = 1'b1;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
            end
            CP_WR: begin
                mem_dwe   = 1'b1;
                mem_addr  = dst_r;
                mem_wdata = hold_r;
            end
            default: ;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master with a behavioural 256x16 registered-read memory.
module tb_dmem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_daddr = 8'h00;
    logic [7:0]  req_len = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        done;
    logic        busy;
    logic        mem_dwe;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    dmem_master #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_daddr(req_daddr), .req_len(req_len),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .done(done), .busy(busy),
        .mem_dwe(mem_dwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    int dwe_total = 0;

    always @(posedge clk) begin
        if (mem_dwe) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (mem_dwe) dwe_total <= dwe_total + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [7:0]  daddr;
        logic [7:0]  len;
        logic [15:0] wdata;
        logic        exp_resp;
        int          exp_edges;
        logic [15:0] exp_data;
        int          exp_dwe;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t st(input logic [7:0] a, input logic [15:0] d);
        return '{2'b01, a, 8'h00, 8'h00, d, 1'b0, 1, 16'h0000, 1};
    endfunction

    function automatic vec_t ld(input logic [7:0] a, input logic [15:0] d);
        return '{2'b00, a, 8'h00, 8'h00, 16'h0000, 1'b1, 2, d, 0};
    endfunction

    function automatic vec_t cp(input logic [7:0] s, input logic [7:0] dst, input logic [7:0] n);
        return '{2'b10, s, dst, n, 16'h0000, 1'b0, 3 * int'(n), 16'h0000, int'(n)};
    endfunction

    task automatic drive(input vec_t v);
        req_op    = v.op;
        req_addr  = v.addr;
        req_daddr = v.daddr;
        req_len   = v.len;
        req_wdata = v.wdata;
        req_valid = 1'b1;
    endtask

    // Edges counted after the accept edge until resp_valid or done is seen.
    task automatic run_req(input vec_t v, output int n, output logic busy_ok, output int dwe);
        int d0;
        busy_ok = 1'b1;
        drive(v);
        @(posedge clk); #1;
        req_valid = 1'b0;
        d0 = dwe_total;
        n = 0;
        while (!(resp_valid || done) && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        dwe = dwe_total - d0;
    endtask

    vec_t vecs[$];
    int   n;
    int   dwe;
    logic bok;
    int   d0;

    initial begin
        vecs.push_back(st(8'h10, 16'h1234));
        vecs.push_back(ld(8'h10, 16'h1234));
        vecs.push_back(st(8'h01, 16'h000a));
        vecs.push_back(st(8'h02, 16'h000b));
        vecs.push_back(st(8'h03, 16'h000c));
        vecs.push_back(cp(8'h01, 8'h80, 8'd3));
        vecs.push_back(ld(8'h80, 16'h000a));
        vecs.push_back(ld(8'h81, 16'h000b));
        vecs.push_back(ld(8'h82, 16'h000c));
        vecs.push_back(st(8'hFE, 16'h1111));
        vecs.push_back(st(8'hFF, 16'h2222));
        vecs.push_back(st(8'h00, 16'h3333));
        vecs.push_back(st(8'h01, 16'h4444));
        vecs.push_back(cp(8'hFE, 8'h40, 8'd4));
        vecs.push_back(ld(8'h40, 16'h1111));
        vecs.push_back(ld(8'h41, 16'h2222));
        vecs.push_back(ld(8'h42, 16'h3333));
        vecs.push_back(ld(8'h43, 16'h4444));
        vecs.push_back(cp(8'h55, 8'h66, 8'd0));
        vecs.push_back('{2'b11, 8'h10, 8'h20, 8'h05, 16'hFFFF, 1'b0, 0, 16'h0000, 0});
        vecs.push_back(st(8'h60, 16'hAAAA));
        vecs.push_back(st(8'h61, 16'hBBBB));
        vecs.push_back(cp(8'h60, 8'h61, 8'd2));
        vecs.push_back(ld(8'h61, 16'hAAAA));
        vecs.push_back(ld(8'h62, 16'hAAAA));
        vecs.push_back(st(8'h20, 16'h0005));
        vecs.push_back(st(8'h21, 16'h0006));
        vecs.push_back(st(8'h22, 16'h0007));
        vecs.push_back(st(8'h23, 16'h0008));
        vecs.push_back(st(8'h92, 16'hDEAD));
        vecs.push_back(st(8'h93, 16'hBEEF));

        // Reset state
        #2;
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_resp_valid", 0, 32'(resp_valid), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_dwe", 0, 32'(mem_dwe), 32'd0);
        chk("rst_addr", 0, 32'(mem_addr), 32'd0);
        chk("rst_wdata", 0, 32'(mem_wdata), 32'd0);
        chk("rst_resp_data", 0, 32'(resp_data), 32'd0);
        chk("rst_ready", 0, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_req(vecs[i], n, bok, dwe);
            chk("kind_resp", i, 32'(resp_valid), 32'(vecs[i].exp_resp));
            chk("kind_done", i, 32'(done), 32'(!vecs[i].exp_resp));
            chk("latency", i, 32'(n), 32'(vecs[i].exp_edges));
            chk("dwe_count", i, 32'(dwe), 32'(vecs[i].exp_dwe));
            chk("busy_held", i, 32'(bok), 32'd1);
            chk("ready_at_pulse", i, 32'(req_ready), 32'd1);
            if (vecs[i].exp_resp) chk("resp_data", i, 32'(resp_data), 32'(vecs[i].exp_data));
            @(posedge clk); #1;
            chk("pulse_width", i, 32'(resp_valid | done), 32'd0);
        end

        // Reset in the third write cycle of a 4-word copy
        drive(cp(8'h20, 8'h90, 8'd4));
        @(posedge clk); #1;
        req_valid = 1'b0;
        d0 = dwe_total;
        repeat (8) begin
            chk("abort_no_done", 0, 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk("abort_pre_dwe", 0, 32'(mem_dwe), 32'd1);
        chk("abort_pre_addr", 0, 32'(mem_addr), 32'h92);
        rst = 1'b1;
        #1;
        chk("abort_busy", 0, 32'(busy), 32'd0);
        chk("abort_dwe", 0, 32'(mem_dwe), 32'd0);
        chk("abort_ready", 0, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("abort_writes", 0, 32'(dwe_total - d0), 32'd2);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_done", 0, 32'(done | resp_valid), 32'd0);
        chk("abort_idle", 0, 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] expd [4];
            expd = '{16'h0005, 16'h0006, 16'hDEAD, 16'hBEEF};
            run_req(ld(8'h90 + 8'(k), 16'h0000), n, bok, dwe);
            chk("abort_mem", k, 32'(resp_data), 32'(expd[k]));
        end
        @(posedge clk); #1;

        // req_valid held high across two loads; the second is accepted in the resp cycle
        drive(ld(8'h80, 16'h0000));
        @(posedge clk); #1;
        chk("b2b_ready0", 0, 32'(req_ready), 32'd0);
        req_addr = 8'h81;
        @(posedge clk); #1;
        chk("b2b_ready1", 0, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("b2b_resp1", 0, 32'(resp_valid), 32'd1);
        chk("b2b_data1", 0, 32'(resp_data), 32'h000a);
        chk("b2b_ready2", 0, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_accept2", 0, 32'(busy), 32'd1);
        chk("b2b_resp_low", 0, 32'(resp_valid), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("b2b_resp2", 0, 32'(resp_valid), 32'd1);
        chk("b2b_data2", 0, 32'(resp_data), 32'h000b);
        @(posedge clk); #1;
        chk("b2b_no_dup", 0, 32'(busy | resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
